// File: rtl/dmem_pipelined.sv
// Pipelined, byte-addressed little-endian data memory with in-order responses.
// Optional DMEM_ZERO_ON_RESET_EN: clear the whole array word by word after reset.
module dmem_pipelined #(
    parameter int DEPTH_BYTES = 2048,
    parameter int READ_LAT    = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              dbg_clear_busy_o
);

    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W       = $clog2(DEPTH_WORDS);
    localparam int LAST        = READ_LAT - 1;

    // Valid/ready: a request transfers on a clock edge where req_valid_i & req_ready_o;
    // a response transfers where rsp_valid_o & rsp_ready_i. Neither valid depends on ready.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        valid_q [READ_LAT];
    logic [31:0] rdata_q [READ_LAT];
    logic        err_q   [READ_LAT];

    logic             advance;
    logic             accept;
    logic             clear_busy;
    logic [1:0]       lane;
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             misaligned;
    logic             req_err;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shifted;
    logic [31:0]      ld_data;
    logic             wr_en;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             s0_valid_d;
    logic [31:0]      s0_rdata_d;
    logic             s0_err_d;

    assign advance     = ~valid_q[LAST] | rsp_ready_i;
    assign req_ready_o = advance & ~rst_i & ~clear_busy;
    assign accept      = req_valid_i & req_ready_o;

    // Responses still in flight when reset arrives are never shown to the consumer.
    assign rsp_valid_o      = valid_q[LAST] & ~rst_i;
    assign rsp_rdata_o      = rdata_q[LAST];
    assign rsp_err_o        = err_q[LAST];
    assign dbg_clear_busy_o = clear_busy;

    always_comb begin
        lane       = req_addr_i[1:0];
        word_idx   = req_addr_i[IDX_W+1:2];
        in_range   = (req_addr_i < ADDR_W'(DEPTH_BYTES));
        misaligned = ((req_size_i == 2'b01) && req_addr_i[0])
                   || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_err    = (req_size_i == 2'b11) | misaligned | ~in_range;

        rd_word    = mem_q[word_idx];
        rd_shifted = rd_word >> {lane, 3'b000};
        ld_data    = '0;
        wr_be      = 4'b0000;
        wr_data    = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                ld_data = req_unsigned_i ? {24'h0, rd_shifted[7:0]}
                                         : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                ld_data = req_unsigned_i ? {16'h0, rd_shifted[15:0]}
                                         : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                wr_be   = 4'b0011 << lane;
                wr_data = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                ld_data = rd_word;
                wr_be   = 4'b1111;
            end
            default: begin
                ld_data = '0;
                wr_be   = 4'b0000;
            end
        endcase

        wr_en      = accept & req_we_i & ~req_err;
        s0_valid_d = accept;
        s0_err_d   = accept & req_err;
        s0_rdata_d = (accept & ~req_we_i & ~req_err) ? ld_data : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                valid_q[i] <= 1'b0;
                rdata_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
        end else if (advance) begin
            valid_q[0] <= s0_valid_d;
            rdata_q[0] <= s0_rdata_d;
            err_q[0]   <= s0_err_d;
            for (int i = 1; i < READ_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

`ifdef DMEM_ZERO_ON_RESET_EN
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_e;

    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             clear_we;

    // Reset parks the FSM in CLEAR at index 0, so a reset during a clear restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        clear_busy = 1'b0;
        clear_we   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clear_busy = 1'b1;
                clear_we   = ~rst_i;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d   = S_IDLE;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_we) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
`else
    assign clear_busy = 1'b0;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
`endif

endmodule
